// File: rtl/hex_entry.sv
// Hex operand entry: debounced key presses capture two switch nibbles into a byte offered over valid/ready.
// Optional debouncer is compiled in when HEXENTRY_DEBOUNCE_EN is defined.
module hex_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       key,
  input  logic       clr,
  output logic [7:0] a,
  output logic       valid,
  input  logic       ready,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    ENTER_HI = 2'b00,
    ENTER_LO = 2'b01,
    SEND     = 2'b10
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
    $error("hex_entry: DEBOUNCE_CYCLES out of range");
  end

  logic [1:0] sync_q;
  logic       level;
  logic       level_q;
  logic       press_c;

  // Two-flop synchronizer for the asynchronous pushbutton.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], key};
  end

`ifdef HEXENTRY_DEBOUNCE_EN
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      level <= 1'b0;
    end else if (sync_q[1] == level) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      level <= ~level;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign press_c = level & ~level_q;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ENTER_HI;
      a_q     <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      valid_q <= valid_d;
    end
  end

  // clr outranks both capture and handshake; presses in SEND are dropped.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    if (clr) begin
      state_d = ENTER_HI;
      a_d     = 8'h00;
    end else begin
      case (state_q)
        ENTER_HI: if (press_c) begin
          a_d     = {sw, 4'h0};
          state_d = ENTER_LO;
        end
        ENTER_LO: if (press_c) begin
          a_d     = {a_q[7:4], sw};
          state_d = SEND;
        end
        SEND: if (valid_q && ready) state_d = ENTER_HI;
        default: state_d = ENTER_HI;
      endcase
    end
    valid_d = (state_d == SEND);
  end

  assign a     = a_q;
  assign valid = valid_q;
  assign phase = state_q;

endmodule

// File: doc/hex_entry.md
# hex_entry

Operand-entry front end for the switch/compare/display datapath. A single pushbutton and a 4-bit switch bank are used to key in an 8-bit value one hex nibble at a time, high nibble first. The assembled byte is offered downstream over a valid/ready handshake. This is the writer side of the 8-bit operand bus that the nibble comparator and seven-segment display logic consume.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples required to accept a key level change; legal range 2..65535.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw  input  4  hex nibble from the switches; sampled only at capture edges.
- key  input  1  raw pushbutton, high while pressed, asynchronous to clk.
- clr  input  1  synchronous clear, clk domain; abandons any entry in progress.
- a  output  8  assembled operand: a[7:4] is the first nibble, a[3:0] the second.
- valid  output  1  a holds a complete operand.
- ready  input  1  downstream accepts a when valid && ready.
- phase  output  2  entry state for the LEDs: 2'b00 ENTER_HI, 2'b01 ENTER_LO, 2'b10 SEND.

## Operation
- Key path: 2-flop synchronizer, then debouncer, then rising-edge detect. The result is a 1-cycle internal pulse, press.
- Debouncer: counter clears whenever the synchronized key equals the debounced level. It increments while they differ. The debounced level toggles when the counter has counted DEBOUNCE_CYCLES mismatching cycles, and the counter returns to 0.
- FSM states:
  - ENTER_HI: on press, a[7:4] <= sw and a[3:0] <= 0; go to ENTER_LO.
  - ENTER_LO: on press, a[3:0] <= sw; go to SEND.
  - SEND: valid = 1 and a is held stable. On valid && ready, go to ENTER_HI; a keeps its value until the next ENTER_HI capture. Presses in SEND are discarded, not queued.
- valid is registered and equals (state == SEND).
- clr has priority over press and handshake. It forces ENTER_HI with a = 8'h00 and valid = 0 on the next edge. Debouncer state is unaffected.
- Press and ready in the same cycle in SEND: the handshake completes, the press is dropped, and the next state is ENTER_HI.
- Reset: a = 8'h00, valid = 0, phase = 2'b00, synchronizer flops = 0, debounced level = 0, counter = 0. A key held through reset release produces one press after the debounce window.

## Timing
- Key to capture latency: with HEXENTRY_DEBOUNCE_EN, sw is captured on edge 3 + DEBOUNCE_CYCLES, counting the first edge that samples key high as edge 1. Without it, capture is on edge 3.
- A glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no press. The release must also be stable for DEBOUNCE_CYCLES before another press can register.
- valid rises on the edge that captures the second nibble. It falls on the first edge where valid && ready is sampled high.
- a is registered and never changes while valid = 1, except on clr.
- A back-to-back press needs at most 2·DEBOUNCE_CYCLES + 4 cycles.

## Configuration
- HEXENTRY_DEBOUNCE_EN defined: the debouncer described above is compiled in, and DEBOUNCE_CYCLES applies.
- HEXENTRY_DEBOUNCE_EN undefined: the debouncer is removed. press is the rising edge of the synchronized key, DEBOUNCE_CYCLES is ignored, and every clean level change counts. This build is for simulation and for test stimulus already debounced externally.

## Test plan
- Basic entry (debounce on, DEBOUNCE_CYCLES=4, ready=1 held):
  - stimulus: sw=4'h3, press key 20 cycles; release; sw=4'hC, press 20 cycles.
  - response: a[7:4]=3 on edge 7 of the first press; a=8'h3C with valid=1 for exactly 1 cycle; phase sequence 00,01,10,00.
- Bounce rejection:
  - stimulus: toggle key high/low every 2 cycles for 40 cycles, then hold high.
  - response: exactly one capture, 7 edges after the final stable high; phase moves 00 to 01 only once.
- Backpressure:
  - stimulus: enter 8'hA5 with ready=0; press twice more; raise ready after 50 cycles.
  - response: valid stays 1 and a stays 8'hA5 throughout; extra presses are ignored; valid drops on the edge after ready rises; phase returns to 00.
- clr mid-entry and clr versus handshake:
  - stimulus: capture high nibble 4'h9, then pulse clr. Separately, in SEND, assert clr and ready in the same cycle.
  - response: a=8'h00, phase=00, valid=0 on the next edge in both cases.
- Async reset mid-operation:
  - stimulus: assert rst in SEND holding 8'h7E, between clock edges.
  - response: a=8'h00, valid=0, phase=00 immediately, without waiting for a clock edge. The first press after release starts a new ENTER_HI capture.
- Debounce disabled (HEXENTRY_DEBOUNCE_EN undefined):
  - stimulus: 1-cycle-wide clean key pulses with sw=4'h1, then sw=4'hF.
  - response: each capture occurs on edge 3; a=8'h1F, valid=1.
